// File: rtl/orb_frame_receiver_pkg.sv
// Shared constants, state encoding and helper types for the Orbita M8 frame receiver.
package orb_frame_receiver_pkg;

  localparam int ORB_WORD_BITS = 12;
  localparam int ORB_ADDR_BITS = 10;
  localparam int ORB_CNT_BITS  = 8;
  localparam int ORB_BCNT_BITS = 4;

  localparam logic [ORB_WORD_BITS-1:0] ORB_SYNC_WORD = 12'hF3A;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCK   = 2'd2
  } orb_state_e;

  typedef logic [ORB_WORD_BITS-1:0] orb_word_t;
  typedef logic [ORB_ADDR_BITS-1:0] orb_addr_t;
  typedef logic [ORB_CNT_BITS-1:0]  orb_cnt_t;

  typedef struct packed {
    orb_word_t data;
    orb_addr_t addr;
    logic      valid;
    logic      frame_start;
    logic      sw;
    logic      sync_err;
  } orb_out_t;

  function automatic orb_addr_t orb_next_addr(input orb_addr_t idx, input orb_addr_t last);
    orb_addr_t nxt;
    if (idx == last) begin
      nxt = '0;
    end else begin
      nxt = idx + ORB_ADDR_BITS'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/orb_frame_receiver_word_shifter.sv
// Serial-to-parallel shifter with a free-running bit counter that can be realigned on a sync hit.
module orb_word_shifter
  import orb_frame_receiver_pkg::*;
(
  input  logic      clk,
  input  logic      rst_ni,
  input  logic      bit_en_i,
  input  logic      serial_i,
  input  logic      align_i,
  output orb_word_t word_o,
  output logic      word_done_o
);

  localparam logic [ORB_BCNT_BITS-1:0] LAST_BIT = ORB_BCNT_BITS'(ORB_WORD_BITS - 1);

  orb_word_t                sh_q;
  orb_word_t                sh_d;
  logic [ORB_BCNT_BITS-1:0] bit_cnt_q;
  logic [ORB_BCNT_BITS-1:0] bit_cnt_d;

  // word_o is the value the register will hold after this strobe, so the
  // sync comparison and word capture both see the freshly shifted bit.
  assign word_o      = {sh_q[ORB_WORD_BITS-2:0], serial_i};
  assign word_done_o = bit_en_i && (bit_cnt_q == LAST_BIT);

  always_comb begin
    sh_d      = sh_q;
    bit_cnt_d = bit_cnt_q;
    if (bit_en_i) begin
      sh_d = word_o;
      if (align_i || (bit_cnt_q == LAST_BIT)) begin
        bit_cnt_d = '0;
      end else begin
        bit_cnt_d = bit_cnt_q + ORB_BCNT_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      sh_q      <= '0;
      bit_cnt_q <= '0;
    end else begin
      sh_q      <= sh_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

endmodule

// File: rtl/orb_frame_receiver.sv
// Orbita M8 receive end: hunts for the frame sync word, confirms it, then flywheels
// word/frame timing and streams addressed words to a double-buffered group memory.
module orb_frame_receiver
  import orb_frame_receiver_pkg::*;
#(
  parameter int        FRAME_WORDS = 1024,
  parameter int        CONFIRM     = 2,
  parameter int        MISS_MAX    = 3,
  parameter orb_word_t SYNC_WORD   = ORB_SYNC_WORD
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     iBitEn,
  input  logic                     iSerial,
  output logic [ORB_WORD_BITS-1:0] oData,
  output logic [ORB_ADDR_BITS-1:0] oAddr,
  output logic                     oValid,
  output logic                     oFrameStart,
  output logic                     oSwitch,
  output logic                     oLocked,
  output logic                     oSyncErr
);

  localparam orb_addr_t LAST_IDX  = ORB_ADDR_BITS'(FRAME_WORDS - 1);
  localparam orb_cnt_t  CONFIRM_C = ORB_CNT_BITS'(CONFIRM);
  localparam orb_cnt_t  MISS_C    = ORB_CNT_BITS'(MISS_MAX);

  orb_state_e state_q, state_d;
  orb_addr_t  widx_q, widx_d;
  orb_cnt_t   hits_q, hits_d;
  orb_cnt_t   miss_q, miss_d;
  orb_out_t   out_q, out_d;

  orb_word_t  word;
  logic       word_done;
  logic       align;
  logic       sync_match;
  orb_cnt_t   hits_inc;
  orb_cnt_t   miss_inc;

  orb_word_shifter u_shifter (
    .clk         (clk),
    .rst_ni      (reset),
    .bit_en_i    (iBitEn),
    .serial_i    (iSerial),
    .align_i     (align),
    .word_o      (word),
    .word_done_o (word_done)
  );

  assign sync_match = (word == SYNC_WORD);
  assign hits_inc   = hits_q + ORB_CNT_BITS'(1);
  assign miss_inc   = miss_q + ORB_CNT_BITS'(1);

  always_comb begin
    state_d           = state_q;
    widx_d            = widx_q;
    hits_d            = hits_q;
    miss_d            = miss_q;
    align             = 1'b0;
    out_d             = out_q;
    out_d.valid       = 1'b0;
    out_d.frame_start = 1'b0;
    out_d.sync_err    = 1'b0;

    unique case (state_q)
      ST_HUNT: begin
        // A hit means the sync word just ended, so the next strobe starts word 1.
        if (iBitEn && sync_match) begin
          state_d = ST_VERIFY;
          align   = 1'b1;
          widx_d  = ORB_ADDR_BITS'(1);
          hits_d  = ORB_CNT_BITS'(1);
        end
      end

      ST_VERIFY: begin
        if (word_done) begin
          widx_d = orb_next_addr(widx_q, LAST_IDX);
          if (widx_q == '0) begin
            if (sync_match) begin
              hits_d = hits_inc;
              if (hits_inc >= CONFIRM_C) begin
                state_d = ST_LOCK;
                miss_d  = '0;
              end
            end else begin
              state_d = ST_HUNT;
              hits_d  = '0;
            end
          end
        end
      end

      ST_LOCK: begin
        if (word_done) begin
          widx_d      = orb_next_addr(widx_q, LAST_IDX);
          out_d.valid = 1'b1;
          out_d.data  = word;
          out_d.addr  = widx_q;
          if (widx_q == '0) begin
            out_d.frame_start = 1'b1;
            if (sync_match) begin
              miss_d = '0;
            end else begin
              out_d.sync_err = 1'b1;
              miss_d         = miss_inc;
              // Losing lock still emits this word; the state drops in the same clk.
              if (miss_inc >= MISS_C) begin
                state_d = ST_HUNT;
                hits_d  = '0;
              end
            end
          end
          if (widx_q == LAST_IDX) begin
            out_d.sw = ~out_q.sw;
          end
        end
      end

      default: begin
        state_d = ST_HUNT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_HUNT;
      widx_q  <= '0;
      hits_q  <= '0;
      miss_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      widx_q  <= widx_d;
      hits_q  <= hits_d;
      miss_q  <= miss_d;
      out_q   <= out_d;
    end
  end

  assign oData       = out_q.data;
  assign oAddr       = out_q.addr;
  assign oValid      = out_q.valid;
  assign oFrameStart = out_q.frame_start;
  assign oSwitch     = out_q.sw;
  assign oSyncErr    = out_q.sync_err;
  assign oLocked     = (state_q == ST_LOCK);

endmodule
